// File: rtl/dcache_pmem_axi.sv
// -----------------------------------------------------------------------------
// dcache_pmem_axi
//
// Bridges the data-cache pmem request port (downstream of the dcache pmem mux)
// onto an AXI4 master with a 32-bit data bus. One burst is in flight at a time;
// all bursts are INCR with 4-byte beats.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   inport_wr_i[3:0]           write byte strobes (nonzero = write beat)
//   inport_rd_i                read burst request
//   inport_len_i[7:0]          beats minus one (first beat only)
//   inport_addr_i[31:0]        burst start address (first beat only)
//   inport_write_data_i[31:0]  write beat data
//   inport_accept_o            request/beat taken this cycle
//   inport_ack_o               one per read beat, one per write burst
//   inport_error_o             response error, qualified by ack
//   inport_read_data_o[31:0]   read data, qualified by ack
//   axi_aw*/axi_w*/axi_b*      AXI4 write address, data, response channels
//   axi_ar*/axi_r*             AXI4 read address and data channels
// -----------------------------------------------------------------------------
module dcache_pmem_axi #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [7:0]  inport_len_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o,

    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,

    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,

    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o,

    output logic        axi_arvalid_o,
    output logic [31:0] axi_araddr_o,
    output logic [3:0]  axi_arid_o,
    output logic [7:0]  axi_arlen_o,
    output logic [1:0]  axi_arburst_o,
    input  logic        axi_arready_i,

    input  logic        axi_rvalid_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic [3:0]  axi_rid_i,
    input  logic        axi_rlast_i,
    output logic        axi_rready_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WRESP = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        awvalid_q, awvalid_d;
    logic [31:0] awaddr_q,  awaddr_d;
    logic [7:0]  awlen_q,   awlen_d;

    logic        wvalid_q,  wvalid_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        wlast_q,   wlast_d;

    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q,  araddr_d;
    logic [7:0]  arlen_q,   arlen_d;

    logic [7:0]  cnt_q,     cnt_d;
    logic [7:0]  len_q,     len_d;

    // Completion tracking for the write burst; the B response may only be
    // acked once both AW and the last W beat have been handshaken.
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic        b_seen_q,  b_seen_d;
    logic [1:0]  bresp_q,   bresp_d;

    logic        ack_q,     ack_d;
    logic        err_q,     err_d;
    logic [31:0] rdata_q,   rdata_d;

    logic        accept_c;
    logic        wr_req_c;
    logic        wlast_next_c;

    // ID fields are not needed with a single outstanding burst.
    logic        unused_ids;
    assign unused_ids = ^{axi_bid_i, axi_rid_i};

    assign wr_req_c     = (inport_wr_i != 4'd0);
    assign wlast_next_c = ((cnt_q + 8'd1) == len_q);

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wlast_d   = wlast_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        b_seen_d  = b_seen_q;
        bresp_d   = bresp_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        accept_c  = 1'b0;

        // Channel handshakes retire valids independently of the FSM so that
        // AW may lead or lag the W beats.
        if (awvalid_q && axi_awready_i) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
        end
        if (wvalid_q && axi_wready_i) begin
            wvalid_d = 1'b0;
            if (wlast_q) begin
                w_done_d = 1'b1;
            end
        end
        if (arvalid_q && axi_arready_i) begin
            arvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                accept_c = 1'b1;
                if (wr_req_c) begin
                    awvalid_d = 1'b1;
                    awaddr_d  = inport_addr_i;
                    awlen_d   = inport_len_i;
                    len_d     = inport_len_i;
                    wvalid_d  = 1'b1;
                    wdata_d   = inport_write_data_i;
                    wstrb_d   = inport_wr_i;
                    wlast_d   = (inport_len_i == 8'd0);
                    cnt_d     = 8'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_seen_d  = 1'b0;
                    bresp_d   = 2'b00;
                    state_d   = (inport_len_i == 8'd0) ? ST_WRESP : ST_WRITE;
                end else if (inport_rd_i) begin
                    arvalid_d = 1'b1;
                    araddr_d  = inport_addr_i;
                    arlen_d   = inport_len_i;
                    state_d   = ST_READ;
                end
            end

            ST_WRITE: begin
                // The W register is free when empty or draining this cycle.
                accept_c = !wvalid_q || axi_wready_i;
                if (accept_c && wr_req_c) begin
                    wvalid_d = 1'b1;
                    wdata_d  = inport_write_data_i;
                    wstrb_d  = inport_wr_i;
                    wlast_d  = wlast_next_c;
                    cnt_d    = cnt_q + 8'd1;
                    if (wlast_next_c) begin
                        state_d = ST_WRESP;
                    end
                end
                // An early (non-compliant) B is remembered until AW/W finish.
                if (axi_bvalid_i) begin
                    b_seen_d = 1'b1;
                    bresp_d  = axi_bresp_i;
                end
            end

            ST_WRESP: begin
                if (axi_bvalid_i) begin
                    b_seen_d = 1'b1;
                    bresp_d  = axi_bresp_i;
                end
                if ((axi_bvalid_i || b_seen_q) && aw_done_q && w_done_q) begin
                    ack_d    = 1'b1;
                    err_d    = axi_bvalid_i ? (axi_bresp_i != 2'b00) : (bresp_q != 2'b00);
                    b_seen_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_READ: begin
                if (axi_rvalid_i) begin
                    ack_d   = 1'b1;
                    rdata_d = axi_rdata_i;
                    err_d   = (axi_rresp_i != 2'b00);
                    if (axi_rlast_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= 32'd0;
            awlen_q   <= 8'd0;
            wvalid_q  <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            wlast_q   <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            cnt_q     <= 8'd0;
            len_q     <= 8'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_seen_q  <= 1'b0;
            bresp_q   <= 2'b00;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wlast_q   <= wlast_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            b_seen_q  <= b_seen_d;
            bresp_q   <= bresp_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Accept is held low while reset is asserted even though IDLE would
    // otherwise advertise it.
    assign inport_accept_o    = rst_n & accept_c;
    assign inport_ack_o       = ack_q;
    assign inport_error_o     = err_q;
    assign inport_read_data_o = rdata_q;

    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = awlen_q;
    assign axi_awburst_o = 2'b01;

    assign axi_wvalid_o  = wvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = wlast_q;

    assign axi_bready_o  = 1'b1;

    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = araddr_q;
    assign axi_arid_o    = AXI_ID;
    assign axi_arlen_o   = arlen_q;
    assign axi_arburst_o = 2'b01;

    assign axi_rready_o  = 1'b1;

endmodule

// File: tb/tb_dcache_pmem_axi.sv
module tb_dcache_pmem_axi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  inport_wr_i;
    logic        inport_rd_i;
    logic [7:0]  inport_len_i;
    logic [31:0] inport_addr_i;
    logic [31:0] inport_write_data_i;
    logic        inport_accept_o, inport_ack_o, inport_error_o;
    logic [31:0] inport_read_data_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_wvalid_o, axi_wlast_o, axi_wready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i, axi_rlast_i, axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic [3:0]  axi_rid_i;

    dcache_pmem_axi dut (
        .clk(clk), .rst_n(rst_n),
        .inport_wr_i(inport_wr_i), .inport_rd_i(inport_rd_i),
        .inport_len_i(inport_len_i), .inport_addr_i(inport_addr_i),
        .inport_write_data_i(inport_write_data_i),
        .inport_accept_o(inport_accept_o), .inport_ack_o(inport_ack_o),
        .inport_error_o(inport_error_o), .inport_read_data_o(inport_read_data_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o),
        .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o),
        .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i),
        .axi_bid_i(axi_bid_i), .axi_bready_o(axi_bready_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o),
        .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o),
        .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i),
        .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i),
        .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
    );

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } req_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
    typedef struct packed { logic [31:0] data; logic err; logic is_wr; } ack_t;

    req_t   exp_aw[$];
    req_t   exp_ar[$];
    wbeat_t exp_w[$];
    ack_t   exp_ack[$];

    int passes = 0;
    int checks = 0;
    int acks_seen = 0;

    // Slave behaviour knobs
    int          aw_delay = 0;
    int          ar_delay = 0;
    int          wready_mode = 0;   // 0 always ready, 1 toggle, 2 random
    bit          r_gap = 1'b0;
    logic [31:0] r_base = 32'd0;
    logic [1:0]  r_resp = 2'b00;
    logic [1:0]  b_resp_cfg = 2'b00;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // AXI slave model plus output scoreboard. Samples at the falling edge,
    // drives just after the rising edge.
    initial begin : slave
        bit          aw_hs, wl_hs, ar_hs, r_hs;
        bit          aw_done_s, wl_done_s;
        int          aw_wait, ar_wait, r_left, r_idx;
        logic [7:0]  ar_len_s;
        req_t        er;
        wbeat_t      ew;
        ack_t        ek;
        bit          ok;
        aw_done_s = 0; wl_done_s = 0; aw_wait = 0; ar_wait = 0;
        r_left = 0; r_idx = 0; ar_len_s = 8'd0;
        forever begin
            @(negedge clk);
            aw_hs = 0; wl_hs = 0; ar_hs = 0; r_hs = 0;
            if (rst_n) begin
                if (axi_awvalid_o && axi_awready_i) begin
                    aw_hs = 1;
                    checks++;
                    if (exp_aw.size() == 0)
                        $display("FAIL aw_unexpected: got addr=%h len=%0d, required none", axi_awaddr_o, axi_awlen_o);
                    else begin
                        er = exp_aw.pop_front();
                        if (axi_awaddr_o !== er.addr || axi_awlen_o !== er.len ||
                            axi_awburst_o !== 2'b01 || axi_awid_o !== 4'd0)
                            $display("FAIL aw: got addr=%h len=%0d burst=%b id=%h, required addr=%h len=%0d burst=01 id=0",
                                     axi_awaddr_o, axi_awlen_o, axi_awburst_o, axi_awid_o, er.addr, er.len);
                        else passes++;
                    end
                end
                if (axi_wvalid_o && axi_wready_i) begin
                    if (axi_wlast_o) wl_hs = 1;
                    checks++;
                    if (exp_w.size() == 0)
                        $display("FAIL w_unexpected: got data=%h, required none", axi_wdata_o);
                    else begin
                        ew = exp_w.pop_front();
                        if (axi_wdata_o !== ew.data || axi_wstrb_o !== ew.strb || axi_wlast_o !== ew.last)
                            $display("FAIL w: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                                     axi_wdata_o, axi_wstrb_o, axi_wlast_o, ew.data, ew.strb, ew.last);
                        else passes++;
                    end
                end
                if (axi_arvalid_o && axi_arready_i) begin
                    ar_hs = 1;
                    ar_len_s = axi_arlen_o;
                    checks++;
                    if (exp_ar.size() == 0)
                        $display("FAIL ar_unexpected: got addr=%h len=%0d, required none", axi_araddr_o, axi_arlen_o);
                    else begin
                        er = exp_ar.pop_front();
                        if (axi_araddr_o !== er.addr || axi_arlen_o !== er.len ||
                            axi_arburst_o !== 2'b01 || axi_arid_o !== 4'd0)
                            $display("FAIL ar: got addr=%h len=%0d burst=%b id=%h, required addr=%h len=%0d burst=01 id=0",
                                     axi_araddr_o, axi_arlen_o, axi_arburst_o, axi_arid_o, er.addr, er.len);
                        else passes++;
                    end
                end
                if (axi_rvalid_i) r_hs = 1;
                if (inport_ack_o) begin
                    acks_seen++;
                    checks++;
                    if (exp_ack.size() == 0)
                        $display("FAIL ack_unexpected: got data=%h err=%b, required no ack", inport_read_data_o, inport_error_o);
                    else begin
                        ek = exp_ack.pop_front();
                        if (ek.is_wr)
                            ok = (inport_error_o === ek.err) && !axi_awvalid_o && !axi_wvalid_o;
                        else
                            ok = (inport_error_o === ek.err) && (inport_read_data_o === ek.data);
                        if (!ok)
                            $display("FAIL ack: got data=%h err=%b awv=%b wv=%b, required data=%h err=%b wr=%b",
                                     inport_read_data_o, inport_error_o, axi_awvalid_o, axi_wvalid_o,
                                     ek.data, ek.err, ek.is_wr);
                        else passes++;
                    end
                end
            end

            @(posedge clk);
            #1;
            if (!rst_n) begin
                axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
                axi_rvalid_i = 0; axi_rlast_i = 0; axi_bvalid_i = 0;
                aw_done_s = 0; wl_done_s = 0; r_left = 0; aw_wait = 0; ar_wait = 0;
                continue;
            end
            if (aw_hs) aw_done_s = 1;
            if (wl_hs) wl_done_s = 1;

            if (axi_awvalid_o) begin axi_awready_i = (aw_wait >= aw_delay); aw_wait++; end
            else begin axi_awready_i = 0; aw_wait = 0; end
            if (axi_arvalid_o) begin axi_arready_i = (ar_wait >= ar_delay); ar_wait++; end
            else begin axi_arready_i = 0; ar_wait = 0; end

            case (wready_mode)
                0: axi_wready_i = 1'b1;
                1: axi_wready_i = ~axi_wready_i;
                default: axi_wready_i = 1'($urandom_range(0, 1));
            endcase

            if (r_hs) begin r_idx++; r_left--; end
            if (ar_hs) begin r_left = int'(ar_len_s) + 1; r_idx = 0; end
            if (r_left > 0) begin
                axi_rvalid_i = r_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
                axi_rdata_i  = r_base + 32'(r_idx);
                axi_rlast_i  = (r_left == 1);
                axi_rresp_i  = r_resp;
            end else begin
                axi_rvalid_i = 0;
                axi_rlast_i  = 0;
            end

            axi_bvalid_i = 0;
            if (aw_done_s && wl_done_s) begin
                axi_bvalid_i = 1;
                axi_bresp_i  = b_resp_cfg;
                aw_done_s = 0;
                wl_done_s = 0;
            end
        end
    end

    task automatic issue_read(input logic [31:0] addr, input logic [7:0] len,
                              input logic [31:0] base, input logic [1:0] resp);
        bit got;
        r_base = base;
        r_resp = resp;
        exp_ar.push_back('{addr: addr, len: len});
        for (int i = 0; i <= int'(len); i++)
            exp_ack.push_back('{data: base + 32'(i), err: (resp != 2'b00), is_wr: 1'b0});
        @(posedge clk); #1;
        inport_rd_i = 1'b1; inport_addr_i = addr; inport_len_i = len;
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (inport_accept_o) begin got = 1; break; end
        end
        checks++;
        if (!got) $display("FAIL rd_accept: got accept=0 for 50 cycles, required 1");
        else passes++;
        @(posedge clk); #1;
        inport_rd_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                            input logic [31:0] dbase, input logic [1:0] bresp, input bit also_rd);
        int timeouts;
        bit got;
        b_resp_cfg = bresp;
        exp_aw.push_back('{addr: addr, len: len});
        for (int i = 0; i <= int'(len); i++)
            exp_w.push_back('{data: dbase + 32'(i), strb: strb, last: (i == int'(len))});
        exp_ack.push_back('{data: 32'd0, err: (bresp != 2'b00), is_wr: 1'b1});
        timeouts = 0;
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge clk); #1;
            inport_wr_i = strb; inport_rd_i = also_rd;
            inport_addr_i = addr; inport_len_i = len;
            inport_write_data_i = dbase + 32'(i);
            got = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (inport_accept_o) begin got = 1; break; end
            end
            if (!got) begin timeouts++; break; end
        end
        @(posedge clk); #1;
        inport_wr_i = 4'd0; inport_rd_i = 1'b0;
        checks++;
        if (timeouts != 0) $display("FAIL wr_accept: got %0d beat timeouts, required 0", timeouts);
        else passes++;
    endtask

    task automatic drain(input string nm, output int acc_hi);
        acc_hi = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_ar.size() == 0 && exp_ack.size() == 0)
                break;
            if (inport_accept_o && !inport_ack_o && exp_ack.size() != 0 && !exp_ack[0].is_wr)
                acc_hi++;
        end
        repeat (5) @(posedge clk);
        checks++;
        if (exp_aw.size() + exp_w.size() + exp_ar.size() + exp_ack.size() != 0)
            $display("FAIL %s_drain: left aw=%0d w=%0d ar=%0d ack=%0d, required all 0", nm,
                     exp_aw.size(), exp_w.size(), exp_ar.size(), exp_ack.size());
        else passes++;
    endtask

    task automatic check_idle(input string nm);
        @(negedge clk);
        checks++;
        if (inport_accept_o !== 1'b1 || axi_awvalid_o || axi_wvalid_o || axi_arvalid_o)
            $display("FAIL %s_idle: got accept=%b awv=%b wv=%b arv=%b, required 1 0 0 0", nm,
                     inport_accept_o, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({inport_accept_o, inport_ack_o, inport_error_o, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o} !== 6'b0)
            $display("FAIL reset_ctrl: got acc=%b ack=%b err=%b awv=%b wv=%b arv=%b, required all 0",
                     inport_accept_o, inport_ack_o, inport_error_o, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o);
        else passes++;
        checks++;
        if (axi_awaddr_o !== 32'd0 || axi_araddr_o !== 32'd0 || axi_awlen_o !== 8'd0 ||
            axi_arlen_o !== 8'd0 || axi_wdata_o !== 32'd0 || axi_wstrb_o !== 4'd0 ||
            axi_wlast_o !== 1'b0 || inport_read_data_o !== 32'd0)
            $display("FAIL reset_data: got awaddr=%h araddr=%h wdata=%h rdata=%h, required all 0",
                     axi_awaddr_o, axi_araddr_o, axi_wdata_o, inport_read_data_o);
        else passes++;
        checks++;
        if (axi_awburst_o !== 2'b01 || axi_arburst_o !== 2'b01 || axi_bready_o !== 1'b1 ||
            axi_rready_o !== 1'b1 || axi_awid_o !== 4'd0 || axi_arid_o !== 4'd0)
            $display("FAIL fixed_outputs: got awburst=%b arburst=%b bready=%b rready=%b, required 01 01 1 1",
                     axi_awburst_o, axi_arburst_o, axi_bready_o, axi_rready_o);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("after_reset");
    endtask

    task automatic test_single_read();
        int acc_hi;
        r_gap = 0; ar_delay = 0;
        issue_read(32'h8000_0010, 8'd0, 32'hDEAD_BEEF, 2'b00);
        drain("single_read", acc_hi);
        check_idle("single_read");
    endtask

    task automatic test_line_fill();
        int acc_hi;
        r_gap = 1; ar_delay = 2;
        issue_read(32'h8000_0100, 8'd7, 32'd0, 2'b00);
        drain("line_fill", acc_hi);
        checks++;
        if (acc_hi != 0) $display("FAIL line_fill_accept: got accept high %0d cycles, required 0", acc_hi);
        else passes++;
        r_gap = 0; ar_delay = 0;
        check_idle("line_fill");
    endtask

    task automatic test_writeback();
        int acc_hi;
        wready_mode = 1;
        do_write(32'h8000_0200, 8'd7, 4'hF, 32'h100, 2'b00, 1'b0);
        drain("writeback", acc_hi);
        wready_mode = 0;
        check_idle("writeback");
    endtask

    task automatic test_write_error();
        int acc_hi;
        do_write(32'h8000_0300, 8'd0, 4'h3, 32'h5555_AAAA, 2'b10, 1'b0);
        drain("write_error", acc_hi);
        check_idle("write_error");
    endtask

    task automatic test_aw_skew();
        int acc_hi;
        aw_delay = 5; wready_mode = 0;
        do_write(32'h8000_0400, 8'd1, 4'hF, 32'h7000, 2'b00, 1'b0);
        drain("aw_skew", acc_hi);
        aw_delay = 0;
        check_idle("aw_skew");
    endtask

    task automatic test_rd_wr_both();
        int acc_hi;
        wready_mode = 2;
        do_write(32'h8000_0500, 8'd0, 4'hC, 32'h1234_5678, 2'b00, 1'b1);
        drain("rd_wr_both", acc_hi);
        wready_mode = 0;
        check_idle("rd_wr_both");
    endtask

    task automatic test_reset_mid_read();
        int acc_hi;
        int start;
        bit got;
        start = acks_seen;
        issue_read(32'h8000_0600, 8'd7, 32'h50, 2'b00);
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (acks_seen >= start + 3) begin got = 1; break; end
        end
        checks++;
        if (!got) $display("FAIL mid_read_progress: got %0d acks, required 3", acks_seen - start);
        else passes++;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inport_accept_o, inport_ack_o, inport_error_o, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o} !== 6'b0 ||
            inport_read_data_o !== 32'd0)
            $display("FAIL mid_read_reset: got acc=%b ack=%b err=%b arv=%b rdata=%h, required all 0",
                     inport_accept_o, inport_ack_o, inport_error_o, axi_arvalid_o, inport_read_data_o);
        else passes++;
        exp_ack.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue_read(32'h8000_1000, 8'd3, 32'hA0, 2'b01);
        drain("post_reset_read", acc_hi);
        check_idle("post_reset_read");
    endtask

    initial begin
        rst_n = 1'b0;
        inport_wr_i = 4'd0; inport_rd_i = 1'b0; inport_len_i = 8'd0;
        inport_addr_i = 32'd0; inport_write_data_i = 32'd0;
        axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
        axi_bvalid_i = 0; axi_bresp_i = 2'b00; axi_bid_i = 4'd0;
        axi_rvalid_i = 0; axi_rdata_i = 32'd0; axi_rresp_i = 2'b00;
        axi_rid_i = 4'd0; axi_rlast_i = 0;

        test_reset();
        test_single_read();
        test_line_fill();
        test_writeback();
        test_write_error();
        test_aw_skew();
        test_rd_wr_both();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
